// File: rtl/spiff42_exp_led_pwm.sv
// rtl/spiff42_exp_led_pwm.sv - eight-channel breathing LED PWM driver
// Optional EXP_MAP_EN selects the exponential brightness map instead of linear.
module spiff42_exp_led_pwm (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [7:0]  cnt;
   logic [15:0] acc;
   logic [7:0]  duty      [8];
   logic [7:0]  duty_next [8];
   logic        unused_in;

   assign unused_in = ena ^ (^uio_in);
   assign uio_out   = 8'h00;
   assign uio_oe    = 8'h00;

   // Triangle: rising over the first half of the phase circle, falling over the second.
   function automatic logic [7:0] tri_level(input logic [15:0] p);
      return p[15] ? ~p[14:7] : p[14:7];
   endfunction

   function automatic logic [7:0] bright_map(input logic [7:0] l);
`ifdef EXP_MAP_EN
      logic [12:0] v;
      v = 13'({1'b1, l[4:0]}) << l[7:5];
      v = (v >> 5) - 13'd1;
      return v[7:0];
`else
      return l;
`endif
   endfunction

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         duty_next[i] = bright_map(tri_level(acc + {3'(i), 13'd0}));
      end
   end

   // Duties and the phase step only move at the frame boundary so a frame never glitches.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= 8'd0;
         acc    <= 16'd0;
         uo_out <= 8'h00;
         for (int i = 0; i < 8; i++) begin
            duty[i] <= 8'd0;
         end
      end else begin
         cnt <= cnt + 8'd1;
         if (cnt == 8'hFF) begin
            acc <= acc + {8'h00, ui_in};
            for (int i = 0; i < 8; i++) begin
               duty[i] <= duty_next[i];
            end
         end
         for (int i = 0; i < 8; i++) begin
            uo_out[i] <= (cnt < duty[i]);
         end
      end
   end

endmodule

// File: tb/tb_spiff42_exp_led_pwm.sv
// tb/tb_spiff42_exp_led_pwm.sv - directed self-checking bench for spiff42_exp_led_pwm
module tb_spiff42_exp_led_pwm;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int errors = 0;
   int checks = 0;
   int hi [8];

`ifdef EXP_MAP_EN
   localparam int D_L128 = 15;
   localparam int D_L255 = 251;
   localparam int D_L127 = 14;
`else
   localparam int D_L128 = 128;
   localparam int D_L255 = 255;
   localparam int D_L127 = 127;
`endif

   spiff42_exp_led_pwm dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run(input int n);
      for (int c = 0; c < 8; c++) hi[c] = 0;
      for (int k = 0; k < n; k++) begin
         tick();
         for (int c = 0; c < 8; c++) hi[c] += int'(uo_out[c]);
      end
   endtask

   initial begin
      rst    = 1'b1;
      ena    = 1'b1;
      ui_in  = 8'h80;
      uio_in = 8'h00;

      for (int k = 0; k < 4; k++) begin
         tick();
         check("rst_uo_out", 32'(uo_out), 32'h0);
         check("rst_uio_out", 32'(uio_out), 32'h0);
         check("rst_uio_oe", 32'(uio_oe), 32'h0);
      end
      check("rst_cnt", 32'(dut.cnt), 32'h0);
      check("rst_acc", 32'(dut.acc), 32'h0);

      // Frozen ramp
      ui_in = 8'h00;
      rst   = 1'b0;
      tick();
      check("first_cnt", 32'(dut.cnt), 32'd1);
      run(255);
      check("frame1_quiet", 32'(hi[0] + hi[2] + hi[4] + hi[6]), 32'd0);
      check("frame1_cnt_wrap", 32'(dut.cnt), 32'd0);
      for (int f = 0; f < 2; f++) begin
         run(256);
         check("frz_ch0", 32'(hi[0]), 32'd0);
         check("frz_ch2", 32'(hi[2]), 32'(D_L128));
         check("frz_ch4", 32'(hi[4]), 32'(D_L255));
         check("frz_ch6", 32'(hi[6]), 32'(D_L127));
      end
      check("frz_acc", 32'(dut.acc), 32'h0);

      // Mid-operation reset
      run(100);
      check("mid_cnt", 32'(dut.cnt), 32'd100);
      check("mid_ch4_high", 32'(uo_out[4]), 32'd1);
      rst   = 1'b1;
      ui_in = 8'd128;
      tick();
      check("mid_rst_uo", 32'(uo_out), 32'h0);
      check("mid_rst_cnt", 32'(dut.cnt), 32'h0);
      check("mid_rst_acc", 32'(dut.acc), 32'h0);
      rst = 1'b0;
      tick();
      check("mid_rel_cnt", 32'(dut.cnt), 32'd1);
      check("mid_rel_uo", 32'(uo_out), 32'h0);

      // Ramp at rate 128 for 256 frames
      run(65535);
      check("ramp_acc", 32'(dut.acc), 32'h8000);
      check("ramp_cnt", 32'(dut.cnt), 32'd0);
      run(256);
      check("ramp_ch0", 32'(hi[0]), 32'(D_L255));
      check("ramp_ch4", 32'(hi[4]), 32'd0);
      check("ramp_acc2", 32'(dut.acc), 32'h8080);

      // Rate is sampled only at the frame edge
      run(50);
      ui_in = 8'd16;
      run(50);
      ui_in = 8'd128;
      run(156);
      check("rate_glitch_acc", 32'(dut.acc), 32'h8100);
      ui_in = 8'd16;
      run(256);
      check("rate16_acc1", 32'(dut.acc), 32'h8110);
      run(256);
      check("rate16_acc2", 32'(dut.acc), 32'h8120);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
